fir_channel_scheduler: RTL and testbench

//  Time-multiplexes one leaky-integrator smoothing datapath (sum += x - (sum>>>k)) across CHANNELS

---
 rtl/fir_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/fir_channel_scheduler.sv | 169 ++++++++++++++++
 tb/tb_fir_channel_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and default sizing for the multi-channel leaky-integrator scheduler.
package fir_sched_pkg;

  localparam int DEF_BITS_X    = 12;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_SHIFT_MAX = 4;

  localparam int BITS_I = DEF_BITS_X + DEF_SHIFT_MAX;
  localparam int CH_W   = $clog2(DEF_CHANNELS);
  localparam int K_W    = $clog2(DEF_SHIFT_MAX + 1);

  typedef logic signed [DEF_BITS_X-1:0] sample_t;
  typedef logic signed [BITS_I-1:0]     sum_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    UPDATE,
    EMIT
  } fsm_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// moves the pointer just past the winner whenever the grant is accepted.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                accept,
  output logic [CHANNELS-1:0] grant,
  output logic [CH_W-1:0]     grant_idx,
  output logic                any_req
);

  logic [CH_W-1:0] ptr;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
    if (any_req) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// One shared leaky-integrator datapath (sum += x - (sum>>>k)) time-multiplexed over CHANNELS streams.
// Define FIR_SCHED_ROUND_EN for round-half-up with saturation on out_data; default is floor truncation.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int  BITS_X    = DEF_BITS_X,
  parameter int  CHANNELS  = DEF_CHANNELS,
  parameter int  SHIFT_MAX = DEF_SHIFT_MAX,
  localparam int BI        = BITS_X + SHIFT_MAX,
  localparam int CW        = $clog2(CHANNELS),
  localparam int KW        = $clog2(SHIFT_MAX + 1)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [CHANNELS-1:0]              in_valid,
  input  logic [CHANNELS-1:0][BITS_X-1:0]  in_data,
  output logic [CHANNELS-1:0]              in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BITS_X-1:0]                out_data,
  output logic [CW-1:0]                    out_ch,
  input  logic                             cfg_we,
  input  logic [CW-1:0]                    cfg_ch,
  input  logic [KW-1:0]                    cfg_shift,
  output logic                             busy
);

  fsm_state_t state, state_nx;

  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic                any_req;
  logic                accept;

  logic signed [BI-1:0] sums   [CHANNELS];
  logic        [KW-1:0] shifts [CHANNELS];

  logic [CW-1:0]            cur_ch;
  logic signed [BITS_X-1:0] cur_x;
  logic signed [BI-1:0]     cur_sum;
  logic [KW-1:0]            cur_k;
  logic                     cfg_hit;

  logic [KW-1:0]            cfg_k;
  logic                     cfg_cur;
  logic                     wb_en;
  logic signed [BI-1:0]     x_ext;
  logic signed [BI-1:0]     leak;
  logic signed [BI-1:0]     sum_n;
  logic signed [BITS_X-1:0] out_nx;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_W     (CW)
  ) u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (in_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    in_ready = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          accept   = 1'b1;
          in_ready = grant;
          state_nx = READ;
        end
      end
      READ:    state_nx = UPDATE;
      UPDATE:  state_nx = EMIT;
      EMIT:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A config write to the channel in flight must leave its freshly zeroed sum alone.
  assign cfg_k   = (cfg_shift > KW'(SHIFT_MAX)) ? KW'(SHIFT_MAX) : cfg_shift;
  assign cfg_cur = cfg_we && (cfg_ch == cur_ch);
  assign wb_en   = (state == UPDATE) && !cfg_hit && !cfg_cur;

  assign x_ext = {{SHIFT_MAX{cur_x[BITS_X-1]}}, cur_x};
  assign leak  = cur_sum >>> cur_k;
  assign sum_n = cur_sum + x_ext - leak;

`ifdef FIR_SCHED_ROUND_EN
  localparam logic signed [BI:0] SAT_HI = (BI+1)'(2**(BITS_X-1) - 1);
  localparam logic signed [BI:0] SAT_LO = (BI+1)'(-(2**(BITS_X-1)));

  logic signed [BI:0] rnd;
  logic signed [BI:0] rnd_sum;
  logic signed [BI:0] rnd_shift;

  // One extra bit keeps sum_n + half-LSB from wrapping before the clamp.
  assign rnd       = $signed(((BI+1)'(1) << cur_k) >> 1);
  assign rnd_sum   = $signed({sum_n[BI-1], sum_n}) + rnd;
  assign rnd_shift = rnd_sum >>> cur_k;

  always_comb begin
    out_nx = BITS_X'(rnd_shift);
    if (rnd_shift > SAT_HI)      out_nx = SAT_HI[BITS_X-1:0];
    else if (rnd_shift < SAT_LO) out_nx = SAT_LO[BITS_X-1:0];
  end
`else
  assign out_nx = BITS_X'(sum_n >>> cur_k);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_ch    <= '0;
      cur_x     <= '0;
      cur_sum   <= '0;
      cur_k     <= '0;
      cfg_hit   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      if (accept) begin
        cur_ch <= grant_idx;
        cur_x  <= in_data[grant_idx];
      end
      if (state == READ) begin
        cur_sum <= sums[cur_ch];
        cur_k   <= shifts[cur_ch];
        cfg_hit <= cfg_cur;
      end
      if (state == UPDATE) begin
        out_data  <= out_nx;
        out_ch    <= cur_ch;
        out_valid <= 1'b1;
      end
      if (state == EMIT && out_ready) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sums[i]   <= '0;
        shifts[i] <= KW'(SHIFT_MAX);
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_we && cfg_ch == CW'(i)) begin
          sums[i]   <= '0;
          shifts[i] <= cfg_k;
        end else if (wb_en && cur_ch == CW'(i)) begin
          sums[i] <= sum_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Randomised bench for fir_channel_scheduler against a transaction-level filter model.
module tb_fir_channel_scheduler;
  import fir_sched_pkg::*;

  localparam int C  = DEF_CHANNELS;
  localparam int BX = DEF_BITS_X;
  localparam int SM = DEF_SHIFT_MAX;
  localparam int CW = $clog2(C);
  localparam int KW = $clog2(SM + 1);

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [C-1:0]          in_valid;
  logic [C-1:0][BX-1:0]  in_data;
  logic [C-1:0]          in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [BX-1:0]         out_data;
  logic [CW-1:0]         out_ch;
  logic                  cfg_we;
  logic [CW-1:0]         cfg_ch;
  logic [KW-1:0]         cfg_shift;
  logic                  busy;

  always #5 clock = ~clock;

  fir_channel_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_shift (cfg_shift),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per-channel sum and shift, rr pointer, and cycles elapsed since the last accept.
  int m_sum [C];
  int m_k   [C];
  int m_rr;
  int m_stage;
  int m_ch;
  int m_x;
  int m_out;
  int m_out_ch;
  int out_log[$];

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_sum[i] = 0;
      m_k[i]   = SM;
    end
    m_rr    = 0;
    m_stage = 0;
  endtask

  function automatic int pick(input logic [C-1:0] v);
    for (int i = 0; i < C; i++) begin
      if (v[(m_rr + i) % C]) return (m_rr + i) % C;
    end
    return -1;
  endfunction

  function automatic int filt_out(input int sn, input int k);
`ifdef FIR_SCHED_ROUND_EN
    int r;
    r = (sn + ((k > 0) ? (1 << (k - 1)) : 0)) >>> k;
    if (r > 2047)  r = 2047;
    if (r < -2048) r = -2048;
    return r;
`else
    logic signed [BX-1:0] t;
    t = BX'(sn >>> k);
    return int'(t);
`endif
  endfunction

  // One clock: drive inputs at the falling edge, check what the DUT shows, then advance the model.
  task automatic apply_stimulus(input logic [C-1:0] v, input logic [C-1:0][BX-1:0] d,
                                input logic ordy, input logic cwe, input int cch, input int cks);
    int g;
    logic [C-1:0] exp_ready;
    logic signed [15:0] sn;
    @(negedge clock);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    cfg_we    = cwe;
    cfg_ch    = CW'(cch);
    cfg_shift = KW'(cks);
    #1;
    g = pick(v);
    exp_ready = '0;
    if (m_stage == 0 && g >= 0) exp_ready[g] = 1'b1;
    check_output("in_ready", in_ready, exp_ready);
    check_output("busy", busy, m_stage != 0);
    check_output("out_valid", out_valid, m_stage == 3);
    if (m_stage == 3) begin
      check_output("out_data", $signed(out_data), m_out);
      check_output("out_ch", out_ch, m_out_ch);
      if (ordy) out_log.push_back(int'($signed(out_data)));
    end
    case (m_stage)
      0: if (g >= 0) begin
        m_ch    = g;
        m_x     = int'($signed(d[g]));
        m_rr    = (g + 1) % C;
        m_stage = 1;
      end
      1: begin
        sn        = 16'(m_sum[m_ch] + m_x - (m_sum[m_ch] >>> m_k[m_ch]));
        m_out     = filt_out(int'(sn), m_k[m_ch]);
        m_out_ch  = m_ch;
        m_sum[m_ch] = int'(sn);
        m_stage   = 2;
      end
      2: m_stage = 3;
      default: if (ordy) m_stage = 0;
    endcase
    if (cwe) begin
      m_k[cch]   = (cks > SM) ? SM : cks;
      m_sum[cch] = 0;
    end
  endtask

  function automatic logic [C-1:0][BX-1:0] fill(input int x);
    logic [C-1:0][BX-1:0] d;
    for (int i = 0; i < C; i++) d[i] = BX'(x);
    return d;
  endfunction

  function automatic logic [C-1:0][BX-1:0] rand_data();
    logic [C-1:0][BX-1:0] d;
    for (int i = 0; i < C; i++) d[i] = BX'($urandom);
    return d;
  endfunction

  initial begin
    int last;
    int bad_mono;
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_shift = '0;
    model_reset();
    #12;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_ch", out_ch, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_in_ready", in_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] pass-through on ch0 with k=0");
    apply_stimulus('0, fill(0), 1'b1, 1'b1, 0, 0);
    apply_stimulus(4'b0001, fill(100), 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) apply_stimulus('0, fill(0), 1'b1, 1'b0, 0, 0);
    check_output("pass_through", (out_log.size() > 0) ? out_log[0] : -9999, 100);

    $display("[TB] step response on ch1, k=4, x=1000");
    out_log.delete();
    apply_stimulus('0, fill(0), 1'b1, 1'b1, 1, 4);
    for (int i = 0; i < 640; i++) apply_stimulus(4'b0010, fill(1000), 1'b1, 1'b0, 0, 0);
`ifdef FIR_SCHED_ROUND_EN
    check_output("step_0", (out_log.size() > 2) ? out_log[0] : -9999, 63);
`else
    check_output("step_0", (out_log.size() > 2) ? out_log[0] : -9999, 62);
`endif
    check_output("step_1", (out_log.size() > 2) ? out_log[1] : -9999, 121);
    check_output("step_2", (out_log.size() > 2) ? out_log[2] : -9999, 176);
    bad_mono = 0;
    for (int i = 1; i < out_log.size(); i++) if (out_log[i] < out_log[i-1]) bad_mono++;
    check_output("step_monotonic", bad_mono, 0);
    last = (out_log.size() > 0) ? out_log[out_log.size()-1] : -9999;
    check_output("step_final", (last >= 999 && last <= 1000), 1);

    $display("[TB] fairness with all channels valid");
    for (int i = 0; i < 48; i++) apply_stimulus('1, rand_data(), 1'b1, 1'b0, 0, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 12; i++) apply_stimulus('1, rand_data(), 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++)  apply_stimulus('1, rand_data(), 1'b1, 1'b0, 0, 0);

    $display("[TB] config write during ch2 update");
    for (int i = 0; i < 5; i++) apply_stimulus('0, fill(0), 1'b1, 1'b0, 0, 0);
    apply_stimulus(4'b0100, fill(300), 1'b1, 1'b0, 0, 0);
    apply_stimulus('0, fill(0), 1'b1, 1'b0, 0, 0);
    apply_stimulus('0, fill(0), 1'b1, 1'b1, 2, 2);
    apply_stimulus('0, fill(0), 1'b1, 1'b0, 0, 0);
    out_log.delete();
    apply_stimulus(4'b0100, fill(400), 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus('0, fill(0), 1'b1, 1'b0, 0, 0);
    check_output("cfg_restart", (out_log.size() > 0) ? out_log[0] : -9999, 100);

    $display("[TB] negative full-scale step");
    for (int i = 0; i < 400; i++)
      apply_stimulus('1, fill(-2048), ($urandom_range(3) != 0), 1'b0, 0, 0);
    for (int i = 0; i < 200; i++)
      apply_stimulus('1, fill(2047), 1'b1, 1'b0, 0, 0);

    $display("[TB] random traffic with config writes");
    for (int i = 0; i < 1500; i++) begin
      apply_stimulus(C'($urandom), rand_data(), ($urandom_range(3) != 0),
                     ($urandom_range(15) == 0), int'($urandom_range(C - 1)),
                     int'($urandom_range(7)));
      if (i == 700) begin
        #2;
        reset_n  = 1'b0;
        in_valid = '0;
        cfg_we   = 1'b0;
        #1;
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_out_data", out_data, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
